// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the cipher-core datapath.
package aes_pkg;

    // Cipher direction; any other encoding is treated as an error.
    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    // Sequencer states of the MixColumns engine, one-hot for glitch-free decode.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } aes_mixcol_seq_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] aes_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by x^2 in GF(2^8).
    function automatic logic [7:0] aes_mul4(input logic [7:0] b);
        return aes_mul2(aes_mul2(b));
    endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// One-column MixColumns / InvMixColumns. The inverse is done as a cheap
// pre-multiplication by {05,00,04,00} followed by the forward transform.
module aes_mix_single_column
    import aes_pkg::*;
(
    input  ciph_op_e        op_i,
    input  logic [3:0][7:0] data_i,
    output logic [3:0][7:0] data_o
);

    logic [3:0][7:0] pre;
    logic [7:0]      u;
    logic [7:0]      v;

    // Optional inverse pre-step, then the forward {02,03,01,01} circulant.
    always_comb begin
        u   = aes_mul4(data_i[0] ^ data_i[2]);
        v   = aes_mul4(data_i[1] ^ data_i[3]);
        pre = data_i;
        if (op_i == CIPH_INV) begin
            pre[0] = data_i[0] ^ u;
            pre[1] = data_i[1] ^ v;
            pre[2] = data_i[2] ^ u;
            pre[3] = data_i[3] ^ v;
        end
        data_o[0] = aes_mul2(pre[0] ^ pre[1]) ^ pre[1] ^ pre[2] ^ pre[3];
        data_o[1] = aes_mul2(pre[1] ^ pre[2]) ^ pre[2] ^ pre[3] ^ pre[0];
        data_o[2] = aes_mul2(pre[2] ^ pre[3]) ^ pre[3] ^ pre[0] ^ pre[1];
        data_o[3] = aes_mul2(pre[3] ^ pre[0]) ^ pre[0] ^ pre[1] ^ pre[2];
    end

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Sequenced MixColumns engine: NumCols single-column units are time-shared
// over the four state columns, one state in flight, valid/ready both sides.
module aes_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NumCols = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  ciph_op_e              op_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [3:0][3:0][7:0]  state_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [3:0][3:0][7:0]  state_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int         MixIters = 4 / NumCols;
    localparam logic [1:0] ColStep  = 2'(NumCols);
    localparam logic [1:0] ColLast  = 2'(4 - NumCols);

    if (NumCols != 1 && NumCols != 2 && NumCols != 4) begin : gen_bad_numcols
        $fatal(1, "aes_mix_columns_seq: NumCols must be 1, 2 or 4 (got %0d)", NumCols);
    end

    aes_mixcol_seq_e                 state_q, state_d;
    logic [1:0]                      col_q;
    ciph_op_e                        op_q;
    logic [3:0][3:0][7:0]            data_q;
    logic [3:0][3:0][7:0]            result_q, result_d;
    logic                            err_q;
    logic                            accept, run, out_hs, op_legal;
    logic [NumCols-1:0][3:0][7:0]    mix_out;

    assign op_legal = (op_i == CIPH_FWD) || (op_i == CIPH_INV);

    // Shared column units; unit i always handles column col_q + i.
    for (genvar i = 0; i < NumCols; i++) begin : gen_col
        logic [1:0] idx;
        assign idx = col_q + 2'(i);
        aes_mix_single_column u_col (
            .op_i   (op_q),
            .data_i (data_q[idx]),
            .data_o (mix_out[i])
        );
    end

    // Merge the current column group into the result state.
    always_comb begin
        result_d = result_q;
        for (int i = 0; i < NumCols; i++) begin
            result_d[col_q + 2'(i)] = mix_out[i];
        end
    end

    // Next-state, handshake decode; clear overrides everything.
    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        busy_o     = 1'b1;
        accept     = 1'b0;
        run        = 1'b0;
        out_hs     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) begin
                    accept  = 1'b1;
                    state_d = op_legal ? RUN : DONE;
                end
            end
            RUN: begin
                run = 1'b1;
                if (col_q == ColLast) state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    out_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Operand, column counter, result and error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q    <= 2'd0;
            op_q     <= CIPH_FWD;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            col_q    <= 2'd0;
            op_q     <= CIPH_FWD;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            col_q    <= 2'd0;
            op_q     <= op_i;
            data_q   <= state_i;
            result_q <= '0;
            err_q    <= !op_legal;
        end else if (run) begin
            col_q    <= col_q + ColStep;
            result_q <= result_d;
        end else if (out_hs) begin
            err_q    <= 1'b0;
        end
    end

    assign out_valid_o = (state_q == DONE);
    assign state_o     = result_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
module tb_aes_mix_columns_seq;
    import aes_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         clear;
    ciph_op_e     op;
    logic         in_valid;
    logic [127:0] state_in;
    logic         out_ready;

    logic         in_ready  [3];
    logic         out_valid [3];
    logic         err       [3];
    logic         busy      [3];
    logic [127:0] state_out [3];

    int n_total = 0;
    int n_pass  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One engine for each legal NumCols: 1, 2, 4.
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        aes_mix_columns_seq #(.NumCols(1 << g)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .clear_i     (clear),
            .op_i        (op),
            .in_valid_i  (in_valid),
            .in_ready_o  (in_ready[g]),
            .state_i     (state_in),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready),
            .state_o     (state_out[g]),
            .err_o       (err[g]),
            .busy_o      (busy[g])
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: textbook GF(2^8) shift-and-add multiply and matrix product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [1:0] op_v, input logic [127:0] s);
        logic [7:0]   c [4];
        logic [127:0] r = '0;
        logic [7:0]   acc;
        if (op_v == 2'b01)      c = '{8'h02, 8'h03, 8'h01, 8'h01};
        else if (op_v == 2'b10) c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else return '0;
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(c[(j - row + 4) % 4], s[32*col + 8*j +: 8]);
                r[32*col + 8*row +: 8] = acc;
            end
        return r;
    endfunction

    // Column word with row 0 in the low byte.
    function automatic logic [31:0] cw(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic chk_idle(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s/nc%0d in_ready", tag, 1 << k), 128'(in_ready[k]), 128'(1));
            chk($sformatf("%s/nc%0d out_valid", tag, 1 << k), 128'(out_valid[k]), 128'(0));
            chk($sformatf("%s/nc%0d err", tag, 1 << k), 128'(err[k]), 128'(0));
            chk($sformatf("%s/nc%0d busy", tag, 1 << k), 128'(busy[k]), 128'(0));
        end
    endtask

    // Present one state, wait for all engines (latency includes the accept
    // edge), hold backpressure for 'hold' cycles, then release.
    task automatic run_txn(input logic [1:0] op_v, input logic [127:0] s,
                           input logic [127:0] exp, input logic exp_err,
                           input int hold, input string tag);
        bit seen [3] = '{0, 0, 0};
        int nseen = 0;
        int c = 1;
        int exp_lat;
        @(negedge clk);
        op = ciph_op_e'(op_v); state_in = s; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        op = ciph_op_e'(2'($urandom_range(1, 2)));
        state_in = {$urandom, $urandom, $urandom, $urandom};
        while (nseen < 3 && c <= 20) begin
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && out_valid[k]) begin
                    seen[k] = 1; nseen++;
                    exp_lat = exp_err ? 1 : (4 / (1 << k)) + 1;
                    chk($sformatf("%s/nc%0d latency", tag, 1 << k), 128'(c), 128'(exp_lat));
                    chk($sformatf("%s/nc%0d state", tag, 1 << k), state_out[k], exp);
                    chk($sformatf("%s/nc%0d err", tag, 1 << k), 128'(err[k]), 128'(exp_err));
                end
            end
            if (nseen < 3) begin @(negedge clk); c++; end
        end
        for (int k = 0; k < 3; k++)
            if (!seen[k]) chk($sformatf("%s/nc%0d timeout out_valid", tag, 1 << k), 128'(0), 128'(1));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("%s/nc%0d hold state", tag, 1 << k), state_out[k], exp);
                chk($sformatf("%s/nc%0d hold in_ready", tag, 1 << k), 128'(in_ready[k]), 128'(0));
                chk($sformatf("%s/nc%0d hold out_valid", tag, 1 << k), 128'(out_valid[k]), 128'(1));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_idle({tag, "/release"});
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [127:0] s;
        logic [127:0] e;
    } vec_t;

    vec_t vt [5];
    logic [127:0] fips_in, fips_out, rs;
    logic [1:0]   rop;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fips_in  = {4{cw(8'hdb, 8'h13, 8'h53, 8'h45)}};
        fips_out = {4{cw(8'h8e, 8'h4d, 8'ha1, 8'hbc)}};
        vt[0] = '{2'b01, fips_in, fips_out};
        vt[1] = '{2'b10, fips_out, fips_in};
        vt[2] = '{2'b01, {4{cw(8'hf2, 8'h0a, 8'h22, 8'h5c)}}, {4{cw(8'h9f, 8'hdc, 8'h58, 8'h9d)}}};
        vt[3] = '{2'b01,
                  {cw(8'hf2, 8'h0a, 8'h22, 8'h5c), cw(8'hdb, 8'h13, 8'h53, 8'h45),
                   32'hc6c6c6c6, 32'h01010101},
                  {cw(8'h9f, 8'hdc, 8'h58, 8'h9d), cw(8'h8e, 8'h4d, 8'ha1, 8'hbc),
                   32'hc6c6c6c6, 32'h01010101}};
        vt[4] = '{2'b10, {32'h01010101, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'h01010101},
                         {32'h01010101, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'h01010101}};

        rst_n = 1'b0; clear = 1'b0; op = CIPH_FWD; in_valid = 1'b0;
        state_in = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("reset");
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset/nc%0d state", 1 << k), state_out[k], '0);

        // Known-answer vectors.
        for (int i = 0; i < 5; i++)
            run_txn(vt[i].op, vt[i].s, vt[i].e, 1'b0, 0, $sformatf("vec%0d", i));

        // Backpressure: ten cycles stalled in DONE.
        run_txn(2'b01, fips_in, fips_out, 1'b0, 10, "bp");

        // Illegal op: straight to DONE with zero result and err set.
        run_txn(2'b11, fips_in, '0, 1'b1, 3, "illegal");

        // Clear during the second RUN cycle, with a competing input.
        @(negedge clk);
        op = CIPH_FWD; state_in = fips_in; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; state_in = vt[2].s;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk_idle("clear");
        for (int k = 0; k < 3; k++)
            chk($sformatf("clear/nc%0d state", 1 << k), state_out[k], '0);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("clear/nc%0d no out_valid", 1 << k), 128'(out_valid[k]), 128'(0));
        run_txn(2'b01, fips_in, fips_out, 1'b0, 0, "after_clear");

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        op = CIPH_INV; state_in = fips_out; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        for (int k = 0; k < 3; k++)
            chk($sformatf("async_rst/nc%0d state", 1 << k), state_out[k], '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(2'b10, fips_out, fips_in, 1'b0, 0, "after_rst");

        // Random states against the reference model, occasional illegal ops.
        for (int i = 0; i < 24; i++) begin
            rs = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       rop = 2'b00;
                1:       rop = 2'b11;
                2, 3, 4: rop = 2'b01;
                default: rop = 2'b10;
            endcase
            run_txn(rop, rs, model(rop, rs), (rop == 2'b00 || rop == 2'b11),
                    i % 3, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
